fetch_seq: RTL and testbench



---
 rtl/rk16_pkg.sv | 37 +++
 rtl/fetch_seq_pc_next.sv | 15 +
 rtl/fetch_seq.sv | 73 +++++++
 tb/tb_fetch_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rk16_pkg.sv
// Shared RK16 definitions: decoder stage codes, opcodes and the fetch sequencer state type.
package rk16_pkg;

  localparam logic [3:0] STG0 = 4'b0001;
  localparam logic [3:0] STG1 = 4'b0010;
  localparam logic [3:0] STG2 = 4'b0100;
  localparam logic [3:0] STG3 = 4'b1000;
  localparam logic [3:0] STG_NONE = 4'b0000;

  localparam int OPCODE_W = 4;
  localparam logic [OPCODE_W-1:0] OP_CALC  = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_CALCI = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_STORE = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_CALIF = 4'h4;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_S0    = 3'd1,
    ST_S1    = 3'd2,
    ST_S2    = 3'd3,
    ST_S3    = 3'd4,
    ST_HALT  = 3'd5
  } fetch_state_e;

  // FETCH and HALT present no stage to the decoder.
  function automatic logic [3:0] stage_of(input fetch_state_e st);
    case (st)
      ST_S0:   stage_of = STG0;
      ST_S1:   stage_of = STG1;
      ST_S2:   stage_of = STG2;
      ST_S3:   stage_of = STG3;
      default: stage_of = STG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fetch_seq_pc_next.sv
// Next-PC selection: control-flow target or sequential increment wrapping at 2^PC_W.
module pc_next #(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] pc,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_addr,
  output logic [PC_W-1:0] pc_nxt
);

  localparam logic [PC_W-1:0] PC_INC = PC_W'(1);

  assign pc_nxt = jump_en ? jump_addr : pc + PC_INC;

endmodule

// File: rtl/fetch_seq.sv
// RK16 instruction fetch and stage sequencer: fetches one word per instruction,
// walks the decoder through STG0..STG3 and commits the next PC at the end of STG3.
module fetch_seq
  import rk16_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            halt,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_addr,
  output logic [31:0]     inst,
  output logic [3:0]      stage,
  output logic [PC_W-1:0] pc,
  output logic            retire
);

  fetch_state_e state, next_state;
  logic            req_q;
  logic            accept;
  logic [PC_W-1:0] pc_nxt;

  pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc        (pc),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .pc_nxt    (pc_nxt)
  );

  // Only an ack seen while the request is actually up counts as the fetch.
  assign accept    = (state == ST_FETCH) && req_q && imem_ack;
  assign imem_req  = req_q;
  assign imem_addr = pc;

  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH: if (accept) next_state = ST_S0;
      ST_S0:    next_state = ST_S1;
      ST_S1:    next_state = ST_S2;
      ST_S2:    next_state = ST_S3;
      ST_S3:    next_state = halt ? ST_HALT : ST_FETCH;
      ST_HALT:  if (!halt) next_state = ST_FETCH;
      default:  next_state = ST_FETCH;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_FETCH;
      req_q  <= 1'b0;
      stage  <= STG_NONE;
      retire <= 1'b0;
      inst   <= 32'h0;
      pc     <= RESET_PC;
    end else begin
      state  <= next_state;
      req_q  <= (next_state == ST_FETCH);
      stage  <= stage_of(next_state);
      retire <= (next_state == ST_S3);
      if (accept) inst <= imem_rdata;
      if (state == ST_S3) pc <= pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed self-checking bench for fetch_seq with hand-computed expectations.
module tb_fetch_seq;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        halt;
  logic        jump_en;
  logic [15:0] jump_addr;
  logic [31:0] inst;
  logic [3:0]  stage;
  logic [15:0] pc;
  logic        retire;

  int total = 0;
  int bad   = 0;

  fetch_seq #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .halt       (halt),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .inst       (inst),
    .stage      (stage),
    .pc         (pc),
    .retire     (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic waitClk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic hlt, input logic jen, input logic [15:0] jaddr);
    imem_ack   = ack;
    imem_rdata = rdata;
    halt       = hlt;
    jump_en    = jen;
    jump_addr  = jaddr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic exp_req, input logic [15:0] exp_pc,
                            input logic [31:0] exp_inst, input logic [3:0] exp_stage,
                            input logic exp_retire);
    checkOutput({tag, ".req"},    {31'h0, imem_req}, {31'h0, exp_req});
    checkOutput({tag, ".addr"},   {16'h0, imem_addr}, {16'h0, exp_pc});
    checkOutput({tag, ".pc"},     {16'h0, pc},        {16'h0, exp_pc});
    checkOutput({tag, ".inst"},   inst,               exp_inst);
    checkOutput({tag, ".stage"},  {28'h0, stage},     {28'h0, exp_stage});
    checkOutput({tag, ".retire"}, {31'h0, retire},    {31'h0, exp_retire});
  endtask

  // Starts in FETCH with req up; ends in the following FETCH with the new pc.
  task automatic runInstr(input string tag, input logic [31:0] word, input logic [15:0] cur_pc,
                          input logic jen, input logic [15:0] jaddr, input logic [15:0] exp_next);
    applyStimulus(1'b1, word, 1'b0, 1'b0, 16'h0);
    waitClk();
    checkState({tag, "_s0"}, 1'b0, cur_pc, word, 4'b0001, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    waitClk();
    checkState({tag, "_s1"}, 1'b0, cur_pc, word, 4'b0010, 1'b0);
    waitClk();
    checkState({tag, "_s2"}, 1'b0, cur_pc, word, 4'b0100, 1'b0);
    waitClk();
    checkState({tag, "_s3"}, 1'b0, cur_pc, word, 4'b1000, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, jen, jaddr);
    waitClk();
    checkState({tag, "_next"}, 1'b1, exp_next, word, 4'b0000, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    waitClk();
    waitClk();
    checkState("reset", 1'b0, 16'h0000, 32'h0, 4'b0000, 1'b0);

    // First instruction after reset, zero-wait memory
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h1234_5671, 1'b0, 1'b0, 16'h0);
    waitClk();
    checkState("i0_fetch", 1'b1, 16'h0000, 32'h0, 4'b0000, 1'b0);
    waitClk();
    checkState("i0_s0", 1'b0, 16'h0000, 32'h1234_5671, 4'b0001, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    waitClk();
    checkState("i0_s1", 1'b0, 16'h0000, 32'h1234_5671, 4'b0010, 1'b0);
    waitClk();
    checkState("i0_s2", 1'b0, 16'h0000, 32'h1234_5671, 4'b0100, 1'b0);
    waitClk();
    checkState("i0_s3", 1'b0, 16'h0000, 32'h1234_5671, 4'b1000, 1'b1);
    waitClk();
    checkState("i0_next", 1'b1, 16'h0001, 32'h1234_5671, 4'b0000, 1'b0);

    // jump_en pulsed in S1 must be ignored
    applyStimulus(1'b1, 32'hA1A1_0001, 1'b0, 1'b0, 16'h0);
    waitClk();
    checkState("s1jmp_s0", 1'b0, 16'h0001, 32'hA1A1_0001, 4'b0001, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    waitClk();
    checkState("s1jmp_s1", 1'b0, 16'h0001, 32'hA1A1_0001, 4'b0010, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 16'h0200);
    waitClk();
    checkState("s1jmp_s2", 1'b0, 16'h0001, 32'hA1A1_0001, 4'b0100, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    waitClk();
    checkState("s1jmp_s3", 1'b0, 16'h0001, 32'hA1A1_0001, 4'b1000, 1'b1);
    waitClk();
    checkState("s1jmp_next", 1'b1, 16'h0002, 32'hA1A1_0001, 4'b0000, 1'b0);

    // Jumps taken in S3
    runInstr("jmp200", 32'hA2A2_0002, 16'h0002, 1'b1, 16'h0200, 16'h0200);
    runInstr("jmp010", 32'hA3A3_0003, 16'h0200, 1'b1, 16'h0010, 16'h0010);

    // Ack delayed: request held for three FETCH cycles in total
    waitClk();
    checkState("wait_c2", 1'b1, 16'h0010, 32'hA3A3_0003, 4'b0000, 1'b0);
    waitClk();
    checkState("wait_c3", 1'b1, 16'h0010, 32'hA3A3_0003, 4'b0000, 1'b0);
    runInstr("dly", 32'hA4A4_0004, 16'h0010, 1'b0, 16'h0, 16'h0011);

    // PC wrap at 16'hFFFF
    runInstr("toFFFF", 32'hA5A5_0005, 16'h0011, 1'b1, 16'hFFFF, 16'hFFFF);
    runInstr("wrap", 32'hA6A6_0006, 16'hFFFF, 1'b0, 16'h0, 16'h0000);

    // halt raised in S1 completes the instruction, then parks in HALT
    applyStimulus(1'b1, 32'hA7A7_0007, 1'b0, 1'b0, 16'h0);
    waitClk();
    checkState("halt_s0", 1'b0, 16'h0000, 32'hA7A7_0007, 4'b0001, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    waitClk();
    checkState("halt_s1", 1'b0, 16'h0000, 32'hA7A7_0007, 4'b0010, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 16'h0);
    waitClk();
    checkState("halt_s2", 1'b0, 16'h0000, 32'hA7A7_0007, 4'b0100, 1'b0);
    waitClk();
    checkState("halt_s3", 1'b0, 16'h0000, 32'hA7A7_0007, 4'b1000, 1'b1);
    waitClk();
    checkState("halt_h1", 1'b0, 16'h0001, 32'hA7A7_0007, 4'b0000, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      waitClk();
      checkState("halt_hold", 1'b0, 16'h0001, 32'hA7A7_0007, 4'b0000, 1'b0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    waitClk();
    checkState("halt_resume", 1'b1, 16'h0001, 32'hA7A7_0007, 4'b0000, 1'b0);

    // Asynchronous reset in the middle of S2
    applyStimulus(1'b1, 32'hA8A8_0008, 1'b0, 1'b0, 16'h0);
    waitClk();
    checkState("rst_s0", 1'b0, 16'h0001, 32'hA8A8_0008, 4'b0001, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
    waitClk();
    waitClk();
    checkState("rst_s2", 1'b0, 16'h0001, 32'hA8A8_0008, 4'b0100, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkState("rst_async", 1'b0, 16'h0000, 32'h0, 4'b0000, 1'b0);
    waitClk();
    checkState("rst_hold", 1'b0, 16'h0000, 32'h0, 4'b0000, 1'b0);
    rst_n = 1'b1;
    waitClk();
    checkState("rst_refetch", 1'b1, 16'h0000, 32'h0, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
